hamming_decoder_stream: RTL and testbench

//  Streaming Hamming(7,4) decoder; consumes 7-bit codewords produced by HammingEncoder
//  (layout {D3,D2,D1,D0,P3,P2,P1}, bit6..bit0) and returns 4-bit data with single-bit correction.
//  Two-stage valid/ready pipeline between the channel/error-injection path and the data sink.

---
 rtl/hamming_decoder_stream.sv | 114 +++++++++++
 tb/tb_hamming_decoder_stream.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder_stream.sv
// Streaming Hamming(7,4) single-error-correcting decoder, two-stage valid/ready pipeline.
// Define HAMDEC_STATS_EN to add err_clr/err_count (saturating count of corrected words).
module hamming_decoder_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       in_cw,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syn,
    output logic             out_corr,
    output logic             out_valid,
    input  logic             out_ready
`ifdef HAMDEC_STATS_EN
    ,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    function automatic logic [2:0] syndrome(input logic [6:0] cw);
        logic s1, s2, s3;
        s1 = cw[0] ^ cw[3] ^ cw[4] ^ cw[6];
        s2 = cw[1] ^ cw[3] ^ cw[5] ^ cw[6];
        s3 = cw[2] ^ cw[4] ^ cw[5] ^ cw[6];
        return {s3, s2, s1};
    endfunction

    // Parity-check columns of cw[2] and cw[3] are 4 and 3, so the syndrome is
    // mapped to the bit it names rather than used directly as a bit index.
    function automatic logic [3:0] correct_data(input logic [6:0] cw, input logic [2:0] syn);
        logic [6:0] mask;
        case (syn)
            3'd1:    mask = 7'b000_0001;
            3'd2:    mask = 7'b000_0010;
            3'd3:    mask = 7'b000_1000;
            3'd4:    mask = 7'b000_0100;
            3'd5:    mask = 7'b001_0000;
            3'd6:    mask = 7'b010_0000;
            3'd7:    mask = 7'b100_0000;
            default: mask = 7'b000_0000;
        endcase
        mask = cw ^ mask;
        return mask[6:3];
    endfunction

    logic       vld_p1;
    logic [6:0] cw_p1;
    logic [2:0] syn_p1;
    logic [3:0] data_fix_p1;
    logic       s1_en;
    logic       s2_en;

    assign s2_en       = !out_valid || out_ready;
    assign s1_en       = !vld_p1 || s2_en;
    assign in_ready    = s1_en;
    assign data_fix_p1 = correct_data(cw_p1, syn_p1);

    // Stage 1: capture codeword and its syndrome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (s1_en) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            cw_p1  <= in_cw;
            syn_p1 <= syndrome(in_cw);
        end
    end

    // Stage 2: corrected data, syndrome and flag to the sink
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 4'd0;
            out_syn   <= 3'd0;
            out_corr  <= 1'b0;
        end else if (s2_en) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_data <= data_fix_p1;
                out_syn  <= syn_p1;
                out_corr <= |syn_p1;
            end
        end
    end

`ifdef HAMDEC_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_corr) begin
            err_count <= sat_inc(err_count);
        end
    end
`endif

endmodule

// File: tb/tb_hamming_decoder_stream.sv
// Randomized and directed bench for hamming_decoder_stream with a nearest-codeword model.
// Works with or without HAMDEC_STATS_EN (stats build uses CNT_W=2 to reach saturation).
module tb_hamming_decoder_stream;

`ifdef HAMDEC_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] in_cw = 7'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_data;
    logic [2:0] out_syn;
    logic       out_corr;
    logic       out_valid;
    logic       out_ready = 1'b1;
`ifdef HAMDEC_STATS_EN
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] err_count;
    int               mcnt = 0;
`endif

    hamming_decoder_stream #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_cw(in_cw),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_syn(out_syn),
        .out_corr(out_corr),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef HAMDEC_STATS_EN
        ,
        .err_clr(err_clr),
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nxfer = 0;

    typedef struct {
        logic [3:0] d;
        logic [2:0] s;
        logic       c;
        int         acc;
    } exp_t;
    exp_t q[$];

    logic       hold_prev = 1'b0;
    logic [3:0] prev_d;
    logic [2:0] prev_s;
    logic       prev_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d, p3, p2, p1};
    endfunction

    // Hamming(7,4) is perfect: every word lies within distance 1 of exactly one codeword.
    function automatic void model(input logic [6:0] cw, output logic [3:0] d,
                                  output logic [2:0] s, output logic c);
        d = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if ($countones(encode(4'(k)) ^ cw) <= 1) d = 4'(k);
        end
        s = {^(cw & 7'b1110100), ^(cw & 7'b1101010), ^(cw & 7'b1011001)};
        c = (encode(d) != cw);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic exp_valid;
        exp_t e;
        if (rst) begin
            q.delete();
            hold_prev = 1'b0;
`ifdef HAMDEC_STATS_EN
            mcnt = 0;
`endif
        end else begin
            exp_valid = (q.size() > 0) && (cyc - q[0].acc >= 1);
            chk("out_valid", out_valid, exp_valid);
            chk("in_ready", in_ready, !(q.size() >= 2 && !out_ready));
            if (out_valid && exp_valid) begin
                chk("out_data", out_data, q[0].d);
                chk("out_syn", out_syn, q[0].s);
                chk("out_corr", out_corr, q[0].c);
            end
            if (hold_prev) begin
                chk("hold_stable", {out_valid, out_data, out_syn, out_corr},
                    {1'b1, prev_d, prev_s, prev_c});
            end
            hold_prev = out_valid && !out_ready;
            prev_d = out_data;
            prev_s = out_syn;
            prev_c = out_corr;
`ifdef HAMDEC_STATS_EN
            chk("err_count", err_count, mcnt);
            if (err_clr) mcnt = 0;
            else if (out_valid && out_ready && out_corr && mcnt < (1 << CNT_W) - 1) mcnt++;
`endif
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                nxfer++;
            end
            if (in_valid && in_ready) begin
                model(in_cw, e.d, e.s, e.c);
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        tick();
    endtask

    task automatic directed(input logic [6:0] cw, input logic [3:0] d,
                            input logic [2:0] s, input logic c);
        out_ready = 1'b1;
        in_cw = cw;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_not_yet", out_valid, 1'b0);
        tick();
        chk("lat_valid", out_valid, 1'b1);
        chk("dir_data", out_data, d);
        chk("dir_syn", out_syn, s);
        chk("dir_corr", out_corr, c);
        drain();
    endtask

    task automatic send_word(input logic [6:0] cw);
        in_cw = cw;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] md;
        logic [2:0] ms;
        logic       mc;
        int         nx0;
        logic [6:0] cw;

        // Pin the model itself with hand-computed values
        chk("model_enc_B", encode(4'hB), 7'h59);
        model(7'h49, md, ms, mc);
        chk("model_49", {md, ms, mc}, {4'hB, 3'd5, 1'b1});
        model(7'h5B, md, ms, mc);
        chk("model_5B", {md, ms, mc}, {4'hB, 3'd2, 1'b1});

        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_fields", {out_data, out_syn, out_corr}, 8'd0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef HAMDEC_STATS_EN
        chk("rst_err_count", err_count, 0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        directed(7'h59, 4'hB, 3'd0, 1'b0);
        directed(7'h49, 4'hB, 3'd5, 1'b1);
        directed(7'h5B, 4'hB, 3'd2, 1'b1);

        // All data values x (no flip, each single bit), back-to-back
        out_ready = 1'b1;
        nx0 = nxfer;
        for (int d = 0; d < 16; d++) begin
            for (int f = 0; f < 8; f++) begin
                cw = encode(4'(d));
                if (f > 0) cw[f-1] = ~cw[f-1];
                in_cw = cw;
                in_valid = 1'b1;
                tick();
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("exhaustive_count", nxfer - nx0, 128);
        drain();

        // Back-pressure with the stream active
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_cw = encode(4'($urandom_range(15)));
            in_valid = 1'b1;
            tick();
        end
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_queue_depth", q.size(), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_cw = encode(4'($urandom_range(15)));
            tick();
        end
        drain();

        // Randomized traffic: 0, 1 or 2 bit errors, random valid/ready
        for (int i = 0; i < 3000; i++) begin
            cw = encode(4'($urandom_range(15)));
            for (int k = $urandom_range(2); k > 0; k--) begin
                cw[$urandom_range(6)] ^= 1'b1;
            end
            in_cw = cw;
            in_valid = ($urandom_range(99) < 70);
            out_ready = ($urandom_range(99) < 60);
`ifdef HAMDEC_STATS_EN
            err_clr = ($urandom_range(99) < 3);
`endif
            tick();
        end
`ifdef HAMDEC_STATS_EN
        err_clr = 1'b0;
`endif
        drain();

        // Reset mid-stream with two words in flight
        out_ready = 1'b0;
        send_word(7'h49);
        send_word(7'h5B);
        chk("pre_rst_full", in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_fields", {out_data, out_syn, out_corr}, 8'd0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_no_stale", nxfer >= 0 && out_valid == 1'b0, 1'b1);

`ifdef HAMDEC_STATS_EN
        for (int i = 0; i < 3; i++) send_word(7'h49);
        drain();
        chk("stats_three", err_count, 3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        chk("stats_clear", err_count, 0);
        for (int i = 0; i < 5; i++) send_word(7'h5B);
        send_word(7'h59);
        drain();
        chk("stats_saturate", err_count, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
